// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of a shared combinational shifter: it latches one request, waits one
// cycle for the result, then holds the response until it is taken. SHIFT_ARB_RR_EN selects round-robin.
module shift_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [DW-1:0]  req1_b,
  output logic [OPW-1:0] sh_op,
  output logic [DW-1:0]  sh_a,
  output logic [DW-1:0]  sh_b,
  input  logic [DW-1:0]  sh_c,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept;
  logic [OPW-1:0] r_sh_op;
  logic [DW-1:0]  r_sh_a;
  logic [DW-1:0]  r_sh_b;
  logic           r_rsp_id;
  logic [DW-1:0]  r_rsp_data;

`ifdef SHIFT_ARB_RR_EN
  // r_last = 1 means port 1 was granted most recently, so port 0 wins the next tie.
  logic r_last;

  assign w_grant0 = req0_valid && (!req1_valid || r_last);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= req1_ready;
    end
  end
`else
  assign w_grant0 = req0_valid;
  assign w_grant1 = req1_valid && !req0_valid;
`endif

  assign req0_ready = (r_state == IDLE) && !rst && w_grant0;
  assign req1_ready = (r_state == IDLE) && !rst && w_grant1;
  assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latches feed the shifter; they change only on an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_op    <= '0;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_sh_op  <= req1_ready ? req1_op : req0_op;
        r_sh_a   <= req1_ready ? req1_a  : req0_a;
        r_sh_b   <= req1_ready ? req1_b  : req0_b;
        r_rsp_id <= req1_ready;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= sh_c;
      end
    end
  end

  assign sh_op     = r_sh_op;
  assign sh_a      = r_sh_a;
  assign sh_b      = r_sh_b;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural shifter on sh_*; tie-break expectations
// follow SHIFT_ARB_RR_EN.
module tb_shift_arbiter;

  localparam logic [3:0] OP_SLL = 4'h1;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'hD;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [3:0]  sh_op;
  logic [31:0] sh_a, sh_b, sh_c;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  shift_arbiter #(.DW(32), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b),
    .sh_op(sh_op), .sh_a(sh_a), .sh_b(sh_b), .sh_c(sh_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Shared shifter as seen by the arbiter.
  always_comb begin
    sh_c = 32'h0;
    case (sh_op)
      OP_SLL:  sh_c = sh_a << sh_b[4:0];
      OP_SRL:  sh_c = sh_a >> sh_b[4:0];
      OP_SRA:  sh_c = $unsigned($signed(sh_a) >>> sh_b[4:0]);
      default: sh_c = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated request with rsp_ready held high, checking handshake timing.
  task automatic run_op(input int port, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    rsp_ready = 1'b1;
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    chk("idle_ready", {30'h0, req1_ready, req0_ready}, (port == 0) ? 32'h1 : 32'h2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("exec_valid", {31'h0, rsp_valid}, 32'h0);
    chk("exec_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
    chk("exec_sh_a", sh_a, a);
    tick();
    chk("resp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("resp_data", rsp_data, exp);
    chk("resp_id", {31'h0, rsp_id}, port);
    tick();
    chk("after_valid", {31'h0, rsp_valid}, 32'h0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_id [4];
    int t;
`ifdef SHIFT_ARB_RR_EN
    exp_id = '{32'h0, 32'h1, 32'h0, 32'h1};
`else
    exp_id = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_op = 4'h0; req1_op = 4'h0;
    req0_a = 32'h0; req1_a = 32'h0; req0_b = 32'h0; req1_b = 32'h0;
    tick(); tick();
    chk("rst_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_sh_a", sh_a, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    run_op(0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_op(1, OP_SLL, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020);

    // Withdrawn request leaves no trace.
    req1_valid = 1'b1; req1_op = OP_SRL; req1_a = 32'hDEAD_BEEF; req1_b = 32'd1;
    #2;
    req1_valid = 1'b0;
    tick(); tick();
    chk("withdraw_sh_a", sh_a, 32'h0000_0001);
    chk("withdraw_valid", {31'h0, rsp_valid}, 32'h0);

    // Backpressure with port 1 pending behind the response.
    req0_valid = 1'b1; req0_op = OP_SRL; req0_a = 32'h1234_5678; req0_b = 32'd4;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = OP_SLL; req1_a = 32'd3; req1_b = 32'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_data", rsp_data, 32'h0123_4567);
      chk("bp_id", {31'h0, rsp_id}, 32'h0);
      chk("bp_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_ready", {30'h0, req1_ready, req0_ready}, 32'h2);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("bp_p1_data", rsp_data, 32'h0000_0006);
    chk("bp_p1_id", {31'h0, rsp_id}, 32'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Both ports held valid.
    req0_valid = 1'b1; req0_op = OP_SLL; req0_a = 32'h1;  req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = OP_SRL; req1_a = 32'h80; req1_b = 32'd4;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!rsp_valid && t < 10) begin
        tick();
        t++;
      end
      chk("both_timeout", {31'h0, rsp_valid}, 32'h1);
      chk("both_id", {31'h0, rsp_id}, exp_id[k]);
      chk("both_data", rsp_data, (exp_id[k] == 32'h0) ? 32'h2 : 32'h8);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();

    // Reset during EXEC drops the operation.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_SRL; req0_a = 32'hF000_0000; req0_b = 32'd8;
    tick();
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_data", rsp_data, 32'h0);
    chk("mid_rst_id", {31'h0, rsp_id}, 32'h0);
    chk("mid_rst_sh", {sh_op, 28'h0} | sh_a | sh_b, 32'h0);
    chk("mid_rst_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
    tick();
    chk("mid_rst_valid2", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    req0_op = OP_SLL; req0_a = 32'h5; req0_b = 32'd2;
    #1;
    chk("post_rst_grant", {30'h0, req1_ready, req0_ready}, 32'h1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("post_rst_valid", {31'h0, rsp_valid}, 32'h1);
    chk("post_rst_data", rsp_data, 32'h0000_0014);
    chk("post_rst_id", {31'h0, rsp_id}, 32'h0);
    tick();
    rsp_ready = 1'b0;

    run_op(0, 4'hF, 32'hFFFF_FFFF, 32'd3, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: DW, 32, operand and result width; only 32 is supported.
REQ-002 Parameter: OPW, 4, width of the alu_op code; encodings for SLL, SRL and SRA come from the shared parameter include.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  out  1  arbiter accepts requester n this cycle.
REQ-007 req0_op / req1_op  in  OPW  shift opcode.
REQ-008 req0_a / req1_a  in  DW  value to be shifted.
REQ-009 req0_b / req1_b  in  DW  shift amount; only bits [4:0] are significant.
REQ-010 sh_op  out  OPW, sh_a  out  DW, sh_b  out  DW  registered operands driven to the shared combinational shifter.
REQ-011 sh_c  in  DW  combinational shifter result.
REQ-012 rsp_valid  out  1  result available.
REQ-013 rsp_ready  in  1  consumer accepts the result.
REQ-014 rsp_id  out  1  index of the requester that owns rsp_data.
REQ-015 rsp_data  out  DW  captured shifter result.

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: reqN_ready = 1 only for the granted port; ready is 0 in EXEC and RESP.
REQ-018 A request is accepted when reqN_valid and reqN_ready are both 1 on a rising edge.
  - On acceptance: op/a/b are latched into sh_op/sh_a/sh_b, the owner is latched into rsp_id, and the FSM moves IDLE -> EXEC.
REQ-019 EXEC lasts exactly one cycle.
  - sh_c is captured into rsp_data at the end of EXEC.
  - FSM moves EXEC -> RESP.
REQ-020 RESP: rsp_valid = 1.
  - rsp_data and rsp_id are held stable until rsp_ready = 1.
  - On that edge the FSM moves to IDLE.
REQ-021 Latency: the request is accepted at edge N and rsp_valid is high after edge N+1. Minimum spacing between accepts is 3 cycles.
REQ-022 Only one request is granted per acceptance; the other port keeps ready = 0 and its valid stays pending.
REQ-023 sh_op, sh_a and sh_b hold their values outside EXEC; no operand reaches the shifter except through the latches.
REQ-024 Opcodes other than SLL, SRL and SRA are accepted and passed to the shifter unchanged; the arbiter returns whatever sh_c gives, which is 0 from the shared shifter.
REQ-025 A requester that withdraws valid before acceptance is not serviced; no state changes.
REQ-026 rsp_ready while in IDLE or EXEC is ignored.

Reset
REQ-027 Asserting rst at any time forces, asynchronously:
  - FSM = IDLE;
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0;
  - sh_op = 0, sh_a = 0, sh_b = 0;
  - round-robin pointer = "last granted port 1".
  Any in-flight operation is dropped.
REQ-028 During reset req0_ready = req1_ready = 0.
REQ-029 After release the first grant follows REQ-030 or REQ-031 from the reset pointer.

Configuration
REQ-030 Macro SHIFT_ARB_RR_EN defined: round-robin arbitration.
  - If both valid in IDLE, grant the port not granted last.
  - If one valid, grant it.
  - The pointer updates on each acceptance.
REQ-031 Macro SHIFT_ARB_RR_EN undefined: fixed priority. Port 0 always wins when both are valid, and the pointer logic is absent.

Verification
REQ-032 Single SRA: req0 op=SRA, a=0x80000000, b=4 -> rsp_valid two edges after accept, rsp_data=0xF8000000, rsp_id=0.
REQ-033 Shift-amount truncation: req1 op=SLL, a=0x00000001, b=0x00000025 -> rsp_data=0x00000020, rsp_id=1.
REQ-034 Simultaneous requests, both held valid:
  - RR build: grant order 0,1,0,1.
  - Fixed build: port 0 serviced repeatedly while it stays valid; port 1 is starved.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable throughout, and both ready signals remain 0; a new accept occurs only after the rsp_ready edge.
REQ-036 Reset mid-operation: assert rst during EXEC of SRL a=0xF0000000, b=8 -> rsp_valid never rises for that op, all outputs are 0, and the next accept after release behaves per REQ-029.
REQ-037 Invalid opcode 4'hF with a=0xFFFFFFFF -> rsp_data=0x00000000, normal handshake timing.
